mc_control_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I core. It steps the datapath through FETCH, DECODE, EXECUTE, MEM and WB. It generates every per-state enable and mux select for the PC, instruction register, ALU, data memory and register file. It also handles memory wait-states, bus timeouts, illegal opcodes and an external halt. It sits beside the decoder inside `cpu` and is the only owner of the CPU state register.

---
 rtl/mc_control_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencer for the RV32I core: FETCH, DECODE, EXECUTE, MEM, WB.
// Owns the CPU state register and drives every per-state enable and mux select.
// It also handles memory wait-states, bus timeouts, illegal opcodes and halt.
module mc_control_fsm #(
  parameter int unsigned Timeout = 15  // max ack wait cycles; 0 disables the timeout
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       imem_ack_i,
  input  logic       dmem_ack_i,
  input  logic       halt_req_i,
  output logic [2:0] state_o,
  output logic       imem_req_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       alu_srcb_o,
  output logic [1:0] alu_op_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       retire_o,
  output logic       halted_o,
  output logic       illegal_o,
  output logic       bus_err_o
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd5,
    StHalt    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,
    ClsR,
    ClsIAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc
  } cls_e;

  localparam int unsigned    CntW   = (Timeout < 2) ? 1 : $clog2(Timeout + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout);

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d, dec_cls;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;
  logic            timeout_hit;
  state_e          boundary;

  // Opcode to instruction class; anything unlisted is illegal (ClsNone).
  always_comb begin
    dec_cls = ClsNone;
    case (opcode_i)
      7'b0110011: dec_cls = ClsR;
      7'b0010011: dec_cls = ClsIAlu;
      7'b0000011: dec_cls = ClsLoad;
      7'b0100011: dec_cls = ClsStore;
      7'b1100011: dec_cls = ClsBranch;
      7'b1101111: dec_cls = ClsJal;
      7'b1100111: dec_cls = ClsJalr;
      7'b0110111: dec_cls = ClsLui;
      7'b0010111: dec_cls = ClsAuipc;
      default:    dec_cls = ClsNone;
    endcase
  end

  assign timeout_hit = (Timeout != 0) && (cnt_q == CntMax);
  assign boundary    = halt_req_i ? StHalt : StFetch;

  // Next-state, wait counter, latched class and sticky trap causes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StFetch: begin
        // An ack in the same cycle as the timeout takes priority.
        if (imem_ack_i) begin
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_cls == ClsNone) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        case (cls_q)
          ClsBranch:         state_d = boundary;
          ClsLoad, ClsStore: state_d = StMem;
          default:           state_d = StWb;
        endcase
      end
      StMem: begin
        if (dmem_ack_i) begin
          state_d = (cls_q == ClsStore) ? boundary : StWb;
        end else if (timeout_hit) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb:    state_d = boundary;
      StHalt:  state_d = halt_req_i ? StHalt : StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    // Every fresh wait window starts from zero.
    if ((state_d == StFetch || state_d == StMem) && state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Sequencer state register, the only copy of the CPU state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      cls_q     <= ClsNone;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  assign halted_o  = (state_q == StHalt);

  // Datapath controls; held low while in reset so FETCH does not request early.
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 2'b00;
    alu_srcb_o = 1'b0;
    alu_op_o   = 2'b00;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    wb_sel_o   = 2'b00;
    retire_o   = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        StFetch: begin
          imem_req_o = 1'b1;
          ir_we_o    = imem_ack_i;
        end
        StExecute: begin
          case (cls_q)
            ClsR: begin
              alu_srcb_o = 1'b0;
              alu_op_o   = 2'b10;
            end
            ClsIAlu: begin
              alu_srcb_o = 1'b1;
              alu_op_o   = 2'b10;
            end
            ClsLui: begin
              alu_srcb_o = 1'b1;
              alu_op_o   = 2'b11;
            end
            ClsBranch: begin
              alu_op_o = 2'b01;
              pc_we_o  = 1'b1;
              pc_sel_o = branch_taken_i ? 2'b01 : 2'b00;
              retire_o = 1'b1;
            end
            // LOAD/STORE/JAL/JALR/AUIPC all add an immediate.
            default: begin
              alu_srcb_o = 1'b1;
              alu_op_o   = 2'b00;
            end
          endcase
        end
        StMem: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (cls_q == ClsStore);
          if (dmem_ack_i && cls_q == ClsStore) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
          end
        end
        StWb: begin
          rf_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          case (cls_q)
            ClsLoad:        wb_sel_o = 2'b01;
            ClsJal, ClsJalr: wb_sel_o = 2'b10;
            default:        wb_sel_o = 2'b00;
          endcase
          case (cls_q)
            ClsJal:  pc_sel_o = 2'b01;
            ClsJalr: pc_sel_o = 2'b10;
            default: pc_sel_o = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level stimulus builds an expected
// per-cycle output trace, and one negedge process compares it to the DUT.
module tb_mc_control_fsm;

  localparam int TO = 15;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, halt_req = 1'b0;
  logic [2:0] state;
  logic       imem_req, ir_we, pc_we, alu_srcb, dmem_req, dmem_we, rf_we;
  logic [1:0] pc_sel, alu_op, wb_sel;
  logic       retire, halted, illegal, bus_err;

  always #5 clk = ~clk;

  mc_control_fsm #(.Timeout(TO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .opcode_i      (opcode),
    .branch_taken_i(branch_taken),
    .imem_ack_i    (imem_ack),
    .dmem_ack_i    (dmem_ack),
    .halt_req_i    (halt_req),
    .state_o       (state),
    .imem_req_o    (imem_req),
    .ir_we_o       (ir_we),
    .pc_we_o       (pc_we),
    .pc_sel_o      (pc_sel),
    .alu_srcb_o    (alu_srcb),
    .alu_op_o      (alu_op),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .rf_we_o       (rf_we),
    .wb_sel_o      (wb_sel),
    .retire_o      (retire),
    .halted_o      (halted),
    .illegal_o     (illegal),
    .bus_err_o     (bus_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_srcb;
    logic [1:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       halted;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  outs_t exp_q[$];
  int    checks = 0, errors = 0;
  int    mon_cyc = 0, mon_ret = 0, mon_halt = 0;
  int    cut_left = 0;
  bit    aborted = 1'b0;
  bit    m_illegal = 1'b0, m_bus_err = 1'b0;

  // The single per-cycle comparison against the expected trace.
  always @(negedge clk) begin
    outs_t act, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {state, imem_req, ir_we, pc_we, pc_sel, alu_srcb, alu_op, dmem_req, dmem_we,
             rf_we, wb_sel, retire, halted, illegal, bus_err};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got st=%0d bits=%05h, want st=%0d bits=%05h",
                 $time, act.st, act, e.st, e);
      end
    end
  end

  // Observes retire/halted so the directed tests can pin absolute latencies.
  always @(negedge clk) begin
    mon_cyc++;
    if (retire === 1'b1) mon_ret = mon_cyc;
    if (halted === 1'b1) mon_halt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    case (o)
      OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t base(input logic [2:0] s);
    outs_t o;
    o         = '0;
    o.st      = s;
    o.halted  = (s == 3'd6);
    o.illegal = m_illegal;
    o.bus_err = m_bus_err;
    return o;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for this cycle.
  task automatic step(input logic rst, input logic [6:0] opc, input logic bt, input logic ia,
                      input logic da, input logic hr, input outs_t e);
    if (aborted) return;
    rst_n        = rst;
    opcode       = opc;
    branch_taken = bt;
    imem_ack     = ia;
    dmem_ack     = da;
    halt_req     = hr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (cut_left > 0) begin
      cut_left--;
      if (cut_left == 0) aborted = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    aborted   = 1'b0;
    cut_left  = 0;
    m_illegal = 1'b0;
    m_bus_err = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 7'($urandom), rb(), rb(), rb(), rb(), '0);
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 7'($urandom), rb(), rb(), rb(), rb(), base(3'd5));
  endtask

  // Runs one instruction: iw/dw are the ack wait cycles, hr is halt_req held
  // for the whole instruction, hlen extra HALT cycles before halt_req drops.
  task automatic do_instr(input logic [6:0] opc, input int iw, input logic bt, input int dw,
                          input logic hr, input int hlen, output bit trapped);
    outs_t e;
    logic  ack;
    trapped = 1'b0;
    for (int k = 0; ; k++) begin
      ack        = (k == iw);
      e          = base(3'd0);
      e.imem_req = 1'b1;
      e.ir_we    = ack;
      step(1'b1, opc, rb(), ack, rb(), hr, e);
      if (ack) break;
      if (k == TO) begin
        m_bus_err = 1'b1;
        trapped   = 1'b1;
        return;
      end
    end
    step(1'b1, opc, rb(), rb(), rb(), hr, base(3'd1));
    if (!is_legal(opc)) begin
      m_illegal = 1'b1;
      trapped   = 1'b1;
      return;
    end
    e = base(3'd2);
    case (opc)
      OpR:    e.alu_op = 2'b10;
      OpI:    begin e.alu_srcb = 1'b1; e.alu_op = 2'b10; end
      OpLui:  begin e.alu_srcb = 1'b1; e.alu_op = 2'b11; end
      OpBranch: begin
        e.alu_op = 2'b01;
        e.pc_we  = 1'b1;
        e.pc_sel = bt ? 2'b01 : 2'b00;
        e.retire = 1'b1;
      end
      default: e.alu_srcb = 1'b1;
    endcase
    step(1'b1, opc, bt, rb(), rb(), hr, e);
    if (opc != OpBranch) begin
      if (opc == OpLoad || opc == OpStore) begin
        for (int k = 0; ; k++) begin
          ack        = (k == dw);
          e          = base(3'd3);
          e.dmem_req = 1'b1;
          e.dmem_we  = (opc == OpStore);
          if (ack && opc == OpStore) begin
            e.pc_we  = 1'b1;
            e.retire = 1'b1;
          end
          step(1'b1, opc, rb(), rb(), ack, hr, e);
          if (ack) break;
          if (k == TO) begin
            m_bus_err = 1'b1;
            trapped   = 1'b1;
            return;
          end
        end
      end
      if (opc != OpStore) begin
        e        = base(3'd4);
        e.rf_we  = 1'b1;
        e.pc_we  = 1'b1;
        e.retire = 1'b1;
        e.wb_sel = (opc == OpLoad) ? 2'b01 : (opc == OpJal || opc == OpJalr) ? 2'b10 : 2'b00;
        e.pc_sel = (opc == OpJal) ? 2'b01 : (opc == OpJalr) ? 2'b10 : 2'b00;
        step(1'b1, opc, rb(), rb(), rb(), hr, e);
      end
    end
    if (hr) begin
      for (int j = 0; j < hlen; j++) step(1'b1, opc, rb(), rb(), rb(), 1'b1, base(3'd6));
      step(1'b1, opc, rb(), rb(), rb(), 1'b0, base(3'd6));
    end
  endtask

  initial begin
    logic [6:0] legal[9] = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui, OpAuipc};
    logic [6:0] opc;
    bit         trapped;
    int         mark, iw, dw, h0;

    @(posedge clk);
    #1;
    do_reset(3);

    mark = mon_cyc;
    do_instr(OpR, 0, 1'b0, 0, 1'b0, 0, trapped);
    chk("add_cycles", mon_ret - mark, 4);

    mark = mon_cyc;
    do_instr(OpLoad, 0, 1'b0, 3, 1'b0, 0, trapped);
    chk("lw_wait3_cycles", mon_ret - mark, 8);

    mark = mon_cyc;
    do_instr(OpBranch, 0, 1'b1, 0, 1'b0, 0, trapped);
    chk("beq_taken_cycles", mon_ret - mark, 3);
    mark = mon_cyc;
    do_instr(OpBranch, 0, 1'b0, 0, 1'b0, 0, trapped);
    chk("beq_not_taken_cycles", mon_ret - mark, 3);

    mark = mon_cyc;
    h0   = mon_halt;
    do_instr(OpStore, 0, 1'b0, 0, 1'b1, 2, trapped);
    chk("sw_halt_cycles", mon_ret - mark, 4);
    chk("sw_halt_len", mon_halt - h0, 3);

    mark = mon_cyc;
    do_instr(OpR, 15, 1'b0, 0, 1'b0, 0, trapped);
    chk("fetch_ack_last_cycle", mon_ret - mark, 19);
    chk("fetch_ack_last_no_err", int'(bus_err), 0);

    mark = mon_cyc;
    do_instr(OpR, 1000, 1'b0, 0, 1'b0, 0, trapped);
    chk("fetch_timeout_cycles", mon_cyc - mark, 16);
    chk("fetch_timeout_state", int'(state), 5);
    chk("fetch_timeout_bus_err", int'(bus_err), 1);
    trap_tail(4);
    do_reset(2);

    do_instr(7'b1111111, 0, 1'b0, 0, 1'b0, 0, trapped);
    chk("illegal_state", int'(state), 5);
    chk("illegal_flag", int'(illegal), 1);
    trap_tail(20);
    do_reset(2);
    chk("illegal_cleared", int'(illegal), 0);

    do_instr(OpStore, 0, 1'b0, 1000, 1'b0, 0, trapped);
    chk("mem_timeout_bus_err", int'(bus_err), 1);
    trap_tail(3);
    do_reset(2);

    cut_left = 3;
    do_instr(OpLoad, 0, 1'b0, 2, 1'b0, 0, trapped);
    do_reset(2);
    chk("midreset_state", int'(state), 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do opc = 7'($urandom); while (is_legal(opc));
      end else begin
        opc = legal[$urandom_range(0, 8)];
      end
      iw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) cut_left = int'($urandom_range(1, 10));
      do_instr(opc, iw, rb(), dw, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
               trapped);
      if (aborted) begin
        do_reset(2);
      end else if (trapped) begin
        trap_tail(int'($urandom_range(2, 6)));
        do_reset(2);
      end
      cut_left = 0;
    end

    @(negedge clk);
    #1;
    chk("trace_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
